sap_register_bank: RTL
======================

// Module: sap_register_bank
// PURPOSE
//  Parametrised bank of DEPTH bus registers, each WIDTH bits, for the 8-bit bus computer datapath.
//  Replaces single-purpose A/B/MAR registers. Supports active-low load, increment, output-enable and
//  register-to-register transfer. Transfers use a 2-cycle internal state machine with a busy flag.
//  Bus output is a driven value plus a drive strobe; there are no internal tristates.
// PARAMETERS
//  WIDTH      8   data width of each register and of the bus
//  DEPTH      4   number of registers (>=2; need not be a power of 2)
//  RESET_VAL  0   value loaded into every register on rst or clear
//  AW (localparam) = $clog2(DEPTH), minimum 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  clear      in   1      active-high sync clear of all registers; aborts any transfer
//  n_load     in   1      active-low: reg[addr] <= bus_in
//  n_inc      in   1      active-low: reg[addr] <= reg[addr] + 1
//  n_xfer     in   1      active-low: start transfer reg[src_addr] -> reg[addr]
//  n_enable   in   1      active-low: drive reg[addr] onto bus_out
//  addr       in   AW     target/read register index
//  src_addr   in   AW     transfer source index
//  bus_in     in   WIDTH  bus data in
//  bus_out    out  WIDTH  reg[addr] when n_enable=0, else 0
//  bus_drive  out  1      =~n_enable (pad output-enable for bus)
//  busy       out  1      high while a transfer is in progress
//  flag_zero  out  1      see CONFIGURATION
//  flag_carry out  1      see CONFIGURATION
// BEHAVIOUR
//  - Priority per edge: rst > clear > (command, only if busy=0). rst/clear: all regs=RESET_VAL,
//    state=IDLE, busy=0, flags=0. bus_out/bus_drive are combinational, 0 when n_enable=1.
//  - Command priority when several are low: n_load > n_inc > n_xfer; lower-priority ones are dropped.
//  - load/inc: single cycle; new value visible on bus_out the cycle after the edge.
//  - inc wraps: all-ones -> 0 (carry generated, see flags). Arithmetic is modulo 2^WIDTH.
//  - Transfer FSM: IDLE --n_xfer=0--> XFER_RD (latch dst=addr, src=src_addr)
//    XFER_RD: hold <= reg[src] -> XFER_WR;  XFER_WR: reg[dst] <= hold -> IDLE.
//    busy=1 in XFER_RD and XFER_WR; load/inc/xfer are ignored while busy; reads stay live.
//    src==dst: legal, takes 2 cycles, value unchanged. Back-to-back xfer accepted the cycle busy falls.
//  - addr/src_addr >= DEPTH: writes and transfers to it are no-ops (still 2 cycles busy);
//    reads of it return 0 with bus_drive still =~n_enable.
//  - clear or rst during XFER_RD/XFER_WR: transfer abandoned, no write, IDLE next cycle.
// CONFIGURATION
//  Macro SAP_REGBANK_FLAGS_EN:
//   defined:   flag_zero <= (written value == 0) on every load/inc/transfer write;
//              flag_carry <= 1 on inc wrap, 0 on any other write; flags hold otherwise.
//   undefined: flag_zero and flag_carry tied to 0; no flag logic synthesised.
// STRUCTURE
//  Package sap_regbank_pkg: state enum {IDLE, XFER_RD, XFER_WR}; op encoding {OP_NONE, OP_LOAD,
//   OP_INC, OP_XFER}; priority-decode function from (n_load, n_inc, n_xfer).
//  Sub-module sap_regbank_cell: one WIDTH register with rst/clear/write-enable/increment,
//   carry-out; instantiated DEPTH times by generate. Top holds FSM, hold register, read mux.
// TESTING
//  1 rst=1 one edge, then n_enable=0 each addr -> bus_out=8'h00, busy=0, flags=0.
//  2 n_load=0 addr=2 bus_in=8'hA5; next cycle n_enable=0 addr=2 -> bus_out=8'hA5, bus_drive=1.
//  3 load 8'hFF to reg1, n_inc=0 addr=1 -> reg1=8'h00; with FLAGS_EN flag_zero=1, flag_carry=1.
//  4 reg0=8'h3C, n_xfer=0 src=0 addr=3 -> busy=1 for 2 cycles, n_load pulse during busy ignored,
//    reg3=8'h3C after, reg0 unchanged.
//  5 start transfer, assert clear in XFER_RD -> all regs=0, busy=0 next cycle, dst not written.
//  6 n_load=0 and n_inc=0 same edge, bus_in=8'h10, reg=8'h05 -> reg=8'h10 (load wins).

Source files
------------

// File: rtl/sap_regbank_pkg.sv
// ----------------------------------------------------------------------------
// sap_regbank_pkg
//   Shared types and helpers for the SAP register bank.
//   - xfer_state_t : transfer sequencer states (IDLE, XFER_RD, XFER_WR)
//   - op_t         : decoded bus command (OP_NONE, OP_LOAD, OP_INC, OP_XFER)
//   - decode_op()  : fixed-priority decode of the active-low command strobes
//                    (load beats inc beats xfer; losers are dropped)
// ----------------------------------------------------------------------------
package sap_regbank_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      XFER_RD = 2'd1,
      XFER_WR = 2'd2
   } xfer_state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_LOAD = 2'd1,
      OP_INC  = 2'd2,
      OP_XFER = 2'd3
   } op_t;

   function automatic op_t decode_op(input logic n_load,
                                     input logic n_inc,
                                     input logic n_xfer);
      op_t op;
      op = OP_NONE;
      if (!n_load) begin
         op = OP_LOAD;
      end else if (!n_inc) begin
         op = OP_INC;
      end else if (!n_xfer) begin
         op = OP_XFER;
      end
      return op;
   endfunction

endpackage

// File: rtl/sap_regbank_cell.sv
// ----------------------------------------------------------------------------
// sap_regbank_cell
//   One WIDTH-bit bus register.
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous reset, active-high (loads RESET_VAL)
//     clear     synchronous clear, active-high (loads RESET_VAL)
//     wr_en     write wr_data this edge (wins over inc_en)
//     wr_data   data to write
//     inc_en    increment modulo 2^WIDTH this edge
//     value     current register contents
//     carry_out high when an increment this edge would wrap to zero
// ----------------------------------------------------------------------------
module sap_regbank_cell #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             inc_en,
   output logic [WIDTH-1:0] value,
   output logic             carry_out
);

   logic [WIDTH-1:0] value_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         value_reg <= RESET_VAL;
      end else if (wr_en) begin
         value_reg <= wr_data;
      end else if (inc_en) begin
         value_reg <= value_reg + 1'b1;
      end
   end

   assign value     = value_reg;
   // All-ones is the only value whose increment wraps.
   assign carry_out = &value_reg;

endmodule

// File: rtl/sap_register_bank.sv
// ----------------------------------------------------------------------------
// sap_register_bank
//   Bank of DEPTH bus registers (WIDTH bits each) for the 8-bit bus computer.
//   Commands are active-low: load (bus_in -> reg[addr]), increment, and a
//   two-cycle register-to-register transfer (reg[src_addr] -> reg[addr]).
//   The bus output is a value plus a drive strobe; no tristates inside.
//
//   Optional feature macro: SAP_REGBANK_FLAGS_EN
//     defined   : flag_zero/flag_carry track the most recent register write
//     undefined : both flags are tied low
//
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     clear                synchronous clear of all registers, aborts transfer
//     n_load/n_inc/n_xfer  active-low commands (priority load > inc > xfer)
//     n_enable             active-low read enable for bus_out
//     addr                 target / read index
//     src_addr             transfer source index
//     bus_in               bus data in
//     bus_out              reg[addr] while n_enable=0, else 0
//     bus_drive            ~n_enable
//     busy                 transfer in progress (commands ignored)
//     flag_zero/flag_carry status flags (see macro above)
// ----------------------------------------------------------------------------
module sap_register_bank
   import sap_regbank_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              AW        = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             n_load,
   input  logic             n_inc,
   input  logic             n_xfer,
   input  logic             n_enable,
   input  logic [AW-1:0]    addr,
   input  logic [AW-1:0]    src_addr,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_drive,
   output logic             busy,
   output logic             flag_zero,
   output logic             flag_carry
);

   xfer_state_t      state_reg, state_next;
   logic [AW-1:0]    dst_reg, src_reg;
   logic [WIDTH-1:0] hold_reg;

   logic [WIDTH-1:0] cell_value [DEPTH];
   logic [DEPTH-1:0] cell_carry;
   logic [DEPTH-1:0] cell_wr_en;
   logic [DEPTH-1:0] cell_inc_en;
   logic [WIDTH-1:0] wr_data;

   op_t              op;
   logic             busy_int;

   logic [WIDTH-1:0] rd_value;
   logic             rd_carry;
   logic             addr_hit;
   logic [WIDTH-1:0] src_value;
   logic             dst_hit;

   assign busy_int = (state_reg != IDLE);

   // Commands are only honoured while idle; during a transfer they vanish.
   assign op = busy_int ? OP_NONE : decode_op(n_load, n_inc, n_xfer);

   // Load and the transfer write can never coincide (load needs idle,
   // the transfer write happens in XFER_WR), so one shared data mux suffices.
   assign wr_data = (op == OP_LOAD) ? bus_in : hold_reg;

   // ------------------------------------------------------------------------
   // Register cells. Indices >= DEPTH simply match no cell, which makes
   // writes/increments/transfers to them no-ops.
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
         assign cell_wr_en[gi]  = ((op == OP_LOAD) && (addr == AW'(gi))) ||
                                  ((state_reg == XFER_WR) && (dst_reg == AW'(gi)));
         assign cell_inc_en[gi] = (op == OP_INC) && (addr == AW'(gi));

         sap_regbank_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .wr_en     (cell_wr_en[gi]),
            .wr_data   (wr_data),
            .inc_en    (cell_inc_en[gi]),
            .value     (cell_value[gi]),
            .carry_out (cell_carry[gi])
         );
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Read muxes: out-of-range indices read as zero.
   // ------------------------------------------------------------------------
   always_comb begin
      rd_value  = '0;
      rd_carry  = 1'b0;
      addr_hit  = 1'b0;
      src_value = '0;
      dst_hit   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == AW'(i)) begin
            rd_value = cell_value[i];
            rd_carry = cell_carry[i];
            addr_hit = 1'b1;
         end
         if (src_reg == AW'(i)) begin
            src_value = cell_value[i];
         end
         if (dst_reg == AW'(i)) begin
            dst_hit = 1'b1;
         end
      end
   end

   assign bus_out   = n_enable ? '0 : rd_value;
   assign bus_drive = ~n_enable;
   assign busy      = busy_int;

   // ------------------------------------------------------------------------
   // Transfer sequencer
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (op == OP_XFER) state_next = XFER_RD;
         XFER_RD: state_next = XFER_WR;
         XFER_WR: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_reg <= IDLE;
         dst_reg   <= '0;
         src_reg   <= '0;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (op == OP_XFER) begin
            dst_reg <= addr;
            src_reg <= src_addr;
         end
         if (state_reg == XFER_RD) begin
            hold_reg <= src_value;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Status flags
   // ------------------------------------------------------------------------
`ifdef SAP_REGBANK_FLAGS_EN
   logic flag_zero_reg, flag_carry_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         flag_zero_reg  <= 1'b0;
         flag_carry_reg <= 1'b0;
      end else if ((op == OP_LOAD) && addr_hit) begin
         flag_zero_reg  <= (bus_in == '0);
         flag_carry_reg <= 1'b0;
      end else if ((op == OP_INC) && addr_hit) begin
         // An increment lands on zero exactly when it wraps.
         flag_zero_reg  <= rd_carry;
         flag_carry_reg <= rd_carry;
      end else if ((state_reg == XFER_WR) && dst_hit) begin
         flag_zero_reg  <= (hold_reg == '0);
         flag_carry_reg <= 1'b0;
      end
   end

   assign flag_zero  = flag_zero_reg;
   assign flag_carry = flag_carry_reg;
`else
   assign flag_zero  = 1'b0;
   assign flag_carry = 1'b0;

   logic unused_flag_terms;
   assign unused_flag_terms = ^{1'b0, rd_carry, addr_hit, dst_hit};
`endif

endmodule
